iq_lane_packer: RTL and testbench

- Parametrised single-clock successor to the fixed 2:1 I/Q rate converter.
- Accepts beats of LANES I and Q sample containers, extracts the ADC_W-bit MSB-aligned sample from each, and packs RATIO consecutive beats into one wide output word.
- Adds valid/ready handshakes on both sides, frame (SOF) realignment and a realignment error counter.
- Sits between the data-converter output and the timing-acquisition / AGC / ILA consumers.

---
 rtl/iq_lane_packer.sv | 131 +++++++++++++
 tb/tb_iq_lane_packer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/iq_lane_packer.sv
// iq_lane_packer
//   Gathers RATIO consecutive beats of LANES I/Q sample containers into one wide
//   output word. From each container it keeps only the ADC_W-bit MSB-aligned sample.
//   An SOF beat that arrives in the middle of a group drops the partial group and
//   starts a new group. Each such forced realignment is counted.
//
// Ports
//   clk          sole clock
//   rst          synchronous reset, active low
//   in_valid     input beat valid
//   in_ready     input beat accepted when in_valid && in_ready
//   in_sof       first beat of a group (qualified by in_valid)
//   in_i/in_q    LANES containers of CONT_W bits; lane k at [k*CONT_W +: CONT_W]
//   out_valid    output word valid
//   out_ready    output word consumed when out_valid && out_ready
//   out_sof      the output word began with an SOF beat
//   out_i/out_q  packed samples; slot s lane k at [(s*LANES+k)*ADC_W +: ADC_W]
//   realign_cnt  saturating count of SOF-forced realignments

module iq_lane_extract #(
   parameter int CONT_W = 16,
   parameter int ADC_W  = 12
) (
   input  logic [CONT_W-1:0] cont,
   output logic [ADC_W-1:0]  samp
);
   assign samp = cont[CONT_W-1 -: ADC_W];

   // The container LSBs below the sample are padding and are discarded.
   if (ADC_W < CONT_W) begin : g_pad
      logic unused_pad;
      assign unused_pad = ^cont[CONT_W-ADC_W-1:0];
   end
endmodule

module iq_lane_packer #(
   parameter int LANES  = 8,
   parameter int CONT_W = 16,
   parameter int ADC_W  = 12,
   parameter int RATIO  = 2,
   parameter int CNT_W  = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic                         in_sof,
   input  logic [LANES*CONT_W-1:0]      in_i,
   input  logic [LANES*CONT_W-1:0]      in_q,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         out_sof,
   output logic [RATIO*LANES*ADC_W-1:0] out_i,
   output logic [RATIO*LANES*ADC_W-1:0] out_q,
   output logic [CNT_W-1:0]             realign_cnt
);
   localparam int PH_W = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(RATIO - 1);

   typedef logic [LANES-1:0][ADC_W-1:0] beat_t;
   typedef logic [RATIO-1:0][LANES-1:0][ADC_W-1:0] word_t;

   beat_t           smp_i, smp_q;
   word_t           acc_i, acc_q, wr_i, wr_q;
   logic [PH_W-1:0] ph, slot;
   logic            sof_flag, sof_nxt;
   logic            accept, realign, complete;

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      iq_lane_extract #(.CONT_W(CONT_W), .ADC_W(ADC_W)) u_ext_i (
         .cont (in_i[k*CONT_W +: CONT_W]),
         .samp (smp_i[k])
      );
      iq_lane_extract #(.CONT_W(CONT_W), .ADC_W(ADC_W)) u_ext_q (
         .cont (in_q[k*CONT_W +: CONT_W]),
         .samp (smp_q[k])
      );
   end

   // The final beat is held back only when the output register cannot take the word.
   // Earlier slots keep filling while the output is stalled.
   assign in_ready = !rst || !out_valid || out_ready || (ph != PH_LAST);
   assign accept   = in_valid && in_ready;

   // A mid-group SOF restarts the group: the beat goes to slot 0.
   // The stale slots are simply overwritten later.
   assign realign  = accept && in_sof && (ph != '0);
   assign slot     = realign ? '0 : ph;
   assign complete = accept && (slot == PH_LAST);
   assign sof_nxt  = (slot == '0) ? in_sof : sof_flag;

   // The accumulator image with the incoming beat merged in.
   // On completion this image is the output word, so the output carries no extra latency.
   for (genvar s = 0; s < RATIO; s++) begin : g_slot
      assign wr_i[s] = (slot == PH_W'(s)) ? smp_i : acc_i[s];
      assign wr_q[s] = (slot == PH_W'(s)) ? smp_q : acc_q[s];
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         ph          <= '0;
         acc_i       <= '0;
         acc_q       <= '0;
         sof_flag    <= 1'b0;
         out_valid   <= 1'b0;
         out_sof     <= 1'b0;
         out_i       <= '0;
         out_q       <= '0;
         realign_cnt <= '0;
      end else begin
         if (accept) begin
            acc_i    <= wr_i;
            acc_q    <= wr_q;
            ph       <= complete ? '0 : slot + PH_W'(1);
            sof_flag <= complete ? 1'b0 : sof_nxt;
         end
         // If a completion and a pop happen in the same cycle, the register reloads
         // and out_valid stays high, so there is no bubble.
         if (complete) begin
            out_valid <= 1'b1;
            out_i     <= wr_i;
            out_q     <= wr_q;
            out_sof   <= sof_nxt;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         if (realign && (realign_cnt != '1))
            realign_cnt <= realign_cnt + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_iq_lane_packer.sv
module tb_iq_lane_packer;
   localparam int L = 8,  C = 16, A = 12, R = 2, W = R*L*A;
   localparam int L4 = 2, A4 = 14, R4 = 4, W4 = R4*L4*A4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst;
   logic            in_valid, in_ready, in_sof, out_valid, out_ready, out_sof;
   logic [L*C-1:0]  in_i, in_q;
   logic [W-1:0]    out_i, out_q;
   logic [7:0]      realign_cnt;
   logic            b_in_valid, b_in_ready, b_in_sof, b_out_valid, b_out_ready, b_out_sof;
   logic [L4*C-1:0] b_in_i, b_in_q;
   logic [W4-1:0]   b_out_i, b_out_q;
   logic [7:0]      b_realign_cnt;

   iq_lane_packer dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
      .in_i(in_i), .in_q(in_q), .out_valid(out_valid), .out_ready(out_ready),
      .out_sof(out_sof), .out_i(out_i), .out_q(out_q), .realign_cnt(realign_cnt)
   );

   iq_lane_packer #(.LANES(L4), .CONT_W(C), .ADC_W(A4), .RATIO(R4), .CNT_W(8)) dut4 (
      .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_sof(b_in_sof),
      .in_i(b_in_i), .in_q(b_in_q), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_sof(b_out_sof), .out_i(b_out_i), .out_q(b_out_q), .realign_cnt(b_realign_cnt)
   );

   int nvec = 0, nerr = 0;

   // Reference model: a list of the beats collected so far plus the word that is
   // currently offered to the consumer.
   typedef struct packed {
      logic             ov, osof, gsof;
      logic [191:0]     wi, wq;
      logic [7:0]       cnt;
      logic [2:0]       n;
      logic [3:0][127:0] bi, bq;
   } mdl_t;
   mdl_t ma, mb;
   logic rdy_a, rdy_b;

   function automatic logic mdl_rdy(mdl_t m, int r, logic ordy, logic rs);
      return !rs || !m.ov || ordy || (int'(m.n) != r - 1);
   endfunction

   function automatic mdl_t mdl_step(mdl_t m, int l, int c, int a, int r,
                                     logic vld, logic sof, logic ordy,
                                     logic [127:0] ci, logic [127:0] cq);
      logic         acc;
      logic [191:0] mask;
      acc = vld && mdl_rdy(m, r, ordy, 1'b1);
      if (!acc) begin
         if (m.ov && ordy) m.ov = 1'b0;
         return m;
      end
      if (sof && m.n != 3'd0) begin
         m.n = 3'd0;
         if (m.cnt != 8'hFF) m.cnt = m.cnt + 8'd1;
      end
      if (m.n == 3'd0) m.gsof = sof;
      m.bi[m.n] = ci;
      m.bq[m.n] = cq;
      m.n = m.n + 3'd1;
      if (int'(m.n) == r) begin
         mask = (192'(1) << a) - 192'(1);
         m.wi = '0;
         m.wq = '0;
         for (int s = 0; s < r; s++)
            for (int k = 0; k < l; k++) begin
               m.wi = m.wi | (((192'(m.bi[s]) >> (k*c + c - a)) & mask) << ((s*l + k)*a));
               m.wq = m.wq | (((192'(m.bq[s]) >> (k*c + c - a)) & mask) << ((s*l + k)*a));
            end
         m.ov   = 1'b1;
         m.osof = m.gsof;
         m.gsof = 1'b0;
         m.n    = 3'd0;
      end else if (m.ov && ordy) begin
         m.ov = 1'b0;
      end
      return m;
   endfunction

   task automatic chk(string nm, logic [191:0] act, logic [191:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Check in_ready on the falling edge, advance the model, then check the registered
   // outputs 1 time unit after the rising edge.
   task automatic tick();
      @(negedge clk);
      rdy_a = in_ready;
      rdy_b = b_in_ready;
      chk("in_ready", 192'(rdy_a), 192'(mdl_rdy(ma, R, out_ready, rst)));
      chk("b_in_ready", 192'(rdy_b), 192'(mdl_rdy(mb, R4, b_out_ready, rst)));
      if (!rst) begin
         ma = '0;
         mb = '0;
      end else begin
         ma = mdl_step(ma, L, C, A, R, in_valid, in_sof, out_ready, in_i, in_q);
         mb = mdl_step(mb, L4, C, A4, R4, b_in_valid, b_in_sof, b_out_ready,
                       128'(b_in_i), 128'(b_in_q));
      end
      @(posedge clk);
      #1;
      chk("out_valid", 192'(out_valid), 192'(ma.ov));
      chk("out_i", 192'(out_i), ma.wi);
      chk("out_q", 192'(out_q), ma.wq);
      if (ma.ov) chk("out_sof", 192'(out_sof), 192'(ma.osof));
      chk("realign_cnt", 192'(realign_cnt), 192'(ma.cnt));
      chk("b_out_valid", 192'(b_out_valid), 192'(mb.ov));
      chk("b_out_i", 192'(b_out_i), 192'(mb.wi[W4-1:0]));
      chk("b_out_q", 192'(b_out_q), 192'(mb.wq[W4-1:0]));
      if (mb.ov) chk("b_out_sof", 192'(b_out_sof), 192'(mb.osof));
      chk("b_realign_cnt", 192'(b_realign_cnt), 192'(mb.cnt));
   endtask

   // In pattern p, lane k holds container {k, 12'hA50 + p*12'h110}: A50, B60, C70, D80.
   function automatic logic [L*C-1:0] pat_i(int p);
      logic [L*C-1:0] v;
      for (int k = 0; k < L; k++) v[k*C +: C] = {4'(k), 12'hA50 + 12'(p) * 12'h110};
      return v;
   endfunction

   // The expected word has slot 0 from pattern pa and slot 1 from pattern pb.
   // Sample = {k, 8'hA5 + p*8'h11}.
   function automatic logic [W-1:0] exp_w(int pa, int pb);
      logic [W-1:0] w;
      for (int k = 0; k < L; k++) begin
         w[k*A +: A]     = {4'(k), 8'hA5 + 8'(pa) * 8'h11};
         w[(L+k)*A +: A] = {4'(k), 8'hA5 + 8'(pb) * 8'h11};
      end
      return w;
   endfunction

   typedef struct {
      logic vld, sof, ordy;
      int   pat;
      logic e_rdy, e_ov, e_osof;
      int   e_w;    // 0: all zero, 1: slots pat0/pat1, 2: slots pat2/pat3
      int   e_cnt;
   } vec_t;
   vec_t tv[12];

   initial begin
      logic [W-1:0]  ew;
      logic [15:0]   c0, c1;
      logic [111:0]  slot3;

      tv[0]  = '{1'b1, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 0, 0};
      tv[1]  = '{1'b1, 1'b0, 1'b1, 1, 1'b1, 1'b1, 1'b0, 1, 0};
      tv[2]  = '{1'b1, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1, 0};
      tv[3]  = '{1'b1, 1'b0, 1'b1, 1, 1'b1, 1'b1, 1'b0, 1, 0};
      tv[4]  = '{1'b1, 1'b0, 1'b0, 2, 1'b1, 1'b1, 1'b0, 1, 0};
      tv[5]  = '{1'b1, 1'b0, 1'b0, 3, 1'b0, 1'b1, 1'b0, 1, 0};
      tv[6]  = '{1'b1, 1'b0, 1'b1, 3, 1'b1, 1'b1, 1'b0, 2, 0};
      tv[7]  = '{1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 2, 0};
      tv[8]  = '{1'b1, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 2, 0};
      tv[9]  = '{1'b1, 1'b1, 1'b1, 2, 1'b1, 1'b0, 1'b0, 2, 1};
      tv[10] = '{1'b1, 1'b0, 1'b1, 3, 1'b1, 1'b1, 1'b1, 2, 1};
      tv[11] = '{1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 2, 1};

      ma = '0;
      mb = '0;
      rst = 1'b0;
      in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b1; in_i = '0; in_q = '0;
      b_in_valid = 1'b0; b_in_sof = 1'b0; b_out_ready = 1'b1; b_in_i = '0; b_in_q = '0;
      tick();
      tick();
      chk("reset_rdy", 192'(rdy_a), 192'(1));
      chk("reset_ov", 192'(out_valid), 192'(0));
      chk("reset_cnt", 192'(realign_cnt), 192'(0));
      rst = 1'b1;

      // Directed cycle-by-cycle table
      for (int i = 0; i < 12; i++) begin
         in_valid  = tv[i].vld;
         in_sof    = tv[i].sof;
         out_ready = tv[i].ordy;
         in_i      = pat_i(tv[i].pat);
         in_q      = ~pat_i(tv[i].pat);
         tick();
         ew = (tv[i].e_w == 0) ? '0 : (tv[i].e_w == 1) ? exp_w(0, 1) : exp_w(2, 3);
         chk($sformatf("tv%0d_rdy", i), 192'(rdy_a), 192'(tv[i].e_rdy));
         chk($sformatf("tv%0d_ov", i), 192'(out_valid), 192'(tv[i].e_ov));
         if (tv[i].e_ov) chk($sformatf("tv%0d_sof", i), 192'(out_sof), 192'(tv[i].e_osof));
         chk($sformatf("tv%0d_i", i), 192'(out_i), 192'(ew));
         chk($sformatf("tv%0d_q", i), 192'(out_q), 192'((tv[i].e_w == 0) ? ew : ~ew));
         chk($sformatf("tv%0d_cnt", i), 192'(realign_cnt), 192'(tv[i].e_cnt));
      end

      // Misaligned SOFs until the counter saturates
      in_valid = 1'b1; in_sof = 1'b0; out_ready = 1'b1;
      in_i = pat_i(0); in_q = ~pat_i(0);
      tick();
      for (int j = 0; j < 300; j++) begin
         in_sof = 1'b1;
         in_i = pat_i(j % 4);
         in_q = ~pat_i(j % 4);
         tick();
      end
      chk("sat_cnt", 192'(realign_cnt), 192'(255));
      chk("sat_no_out", 192'(out_valid), 192'(0));
      in_sof = 1'b0; in_i = pat_i(1); in_q = ~pat_i(1);
      tick();
      chk("sof_word_ov", 192'(out_valid), 192'(1));
      chk("sof_word_sof", 192'(out_sof), 192'(1));
      chk("sof_word_i", 192'(out_i), 192'(exp_w(3, 1)));

      // Reset in the middle of a group while a word is still held
      out_ready = 1'b0; in_i = pat_i(2); in_q = ~pat_i(2);
      tick();
      chk("prerst_ov", 192'(out_valid), 192'(1));
      rst = 1'b0; in_valid = 1'b0;
      tick();
      chk("rst_rdy", 192'(rdy_a), 192'(1));
      chk("rst_ov", 192'(out_valid), 192'(0));
      chk("rst_i", 192'(out_i), 192'(0));
      chk("rst_cnt", 192'(realign_cnt), 192'(0));
      rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      in_i = pat_i(0); in_q = ~pat_i(0);
      tick();
      in_i = pat_i(1); in_q = ~pat_i(1);
      tick();
      chk("postrst_ov", 192'(out_valid), 192'(1));
      chk("postrst_i", 192'(out_i), 192'(exp_w(0, 1)));
      in_valid = 1'b0;

      // RATIO=4 instance: check that slot 3 lands at [111:84]
      c0 = '0; c1 = '0;
      b_in_valid = 1'b1;
      for (int s = 0; s < 4; s++) begin
         c0 = {4'(s), 4'd0, 8'h5C};
         c1 = {4'(s), 4'd1, 8'h5C};
         b_in_i = {c1, c0};
         b_in_q = ~{c1, c0};
         tick();
      end
      slot3 = b_out_i;
      chk("r4_ov", 192'(b_out_valid), 192'(1));
      chk("r4_slot3", 192'(slot3[111:84]), 192'({c1[15:2], c0[15:2]}));
      b_in_valid = 1'b0;

      // Random traffic on both instances
      for (int n = 0; n < 3000; n++) begin
         in_valid    = ($urandom_range(0, 3) != 0);
         in_sof      = ($urandom_range(0, 7) == 0);
         out_ready   = ($urandom_range(0, 3) != 0);
         in_i        = {$urandom(), $urandom(), $urandom(), $urandom()};
         in_q        = {$urandom(), $urandom(), $urandom(), $urandom()};
         b_in_valid  = ($urandom_range(0, 3) != 0);
         b_in_sof    = ($urandom_range(0, 5) == 0);
         b_out_ready = ($urandom_range(0, 2) != 0);
         b_in_i      = $urandom();
         b_in_q      = $urandom();
         tick();
      end
      in_valid = 1'b0; b_in_valid = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
